// File: rtl/add11_reg_if.sv
// Operand/result bundle for add11_reg: master drives operands, slave returns the registered sum.
interface add11_reg_if #(
    parameter int WIDTH = 11
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             out_valid;

    modport master (
        output a, b, cin, in_valid,
        input  s, cout, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
        output s, cout, out_valid
    );
endinterface

// File: rtl/add11_reg.sv
// Registered grouped carry-lookahead adder. Define ADDER_PIPE2_EN for a two-stage
// split (low half, then upper half from the registered carry): latency 2 instead of 1.

// Combinational two-level carry-lookahead adder; ripple is confined to one group.
module add11_reg_cla #(
    parameter int N     = 11,
    parameter int GROUP = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    localparam int NG = (N + GROUP - 1) / GROUP;

    logic [N-1:0]  g;
    logic [N-1:0]  p;
    logic [N-1:0]  c;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;
    logic          prod;
    logic          carry;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin : group_gp
        gg = '0;
        gp = '0;
        for (int i = 0; i < N; i++) begin
            if (i % GROUP == 0) begin
                gg[i / GROUP] = g[i];
                gp[i / GROUP] = p[i];
            end else begin
                gg[i / GROUP] = g[i] | (p[i] & gg[i / GROUP]);
                gp[i / GROUP] = gp[i / GROUP] & p[i];
            end
        end
    end

    // Each group carry is a flat sum of products over lower groups, not a chain.
    always_comb begin : lookahead
        gc    = '0;
        prod  = 1'b0;
        gc[0] = cin;
        for (int k = 1; k <= NG; k++) begin
            prod = cin;
            for (int m = 0; m < k; m++) prod = prod & gp[m];
            gc[k] = prod;
            for (int j = 0; j < k; j++) begin
                prod = gg[j];
                for (int m = j + 1; m < k; m++) prod = prod & gp[m];
                gc[k] = gc[k] | prod;
            end
        end
    end

    always_comb begin : bit_carries
        c     = '0;
        carry = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i % GROUP == 0) carry = gc[i / GROUP];
            c[i]  = carry;
            carry = g[i] | (p[i] & carry);
        end
    end

    assign s    = p ^ c;
    assign cout = gc[NG];
endmodule

// Handshake: in_valid qualifies a/b/cin at a rising edge; there is no ready, so every
// valid beat is taken. out_valid qualifies s/cout, which hold their value between beats.
module add11_reg #(
    parameter int WIDTH = 11,
    parameter int GROUP = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    add11_reg_if.slave   bus
);
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             out_valid_q;

    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = out_valid_q;

`ifdef ADDER_PIPE2_EN
    localparam int L = (WIDTH + 1) / 2;
    localparam int H = WIDTH - L;

    logic [L-1:0] lo_sum;
    logic [L-1:0] lo_s_q;
    logic         lo_co;
    logic         lo_c_q;
    logic [H-1:0] a_hi_q;
    logic [H-1:0] b_hi_q;
    logic [H-1:0] hi_sum;
    logic         hi_co;
    logic         v1_q;

    add11_reg_cla #(.N(L), .GROUP(GROUP)) u_lo (
        .a(bus.a[L-1:0]), .b(bus.b[L-1:0]), .cin(bus.cin),
        .s(lo_sum), .cout(lo_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_s_q <= '0;
            lo_c_q <= 1'b0;
            a_hi_q <= '0;
            b_hi_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                lo_s_q <= lo_sum;
                lo_c_q <= lo_co;
                a_hi_q <= bus.a[WIDTH-1:L];
                b_hi_q <= bus.b[WIDTH-1:L];
            end
        end
    end

    add11_reg_cla #(.N(H), .GROUP(GROUP)) u_hi (
        .a(a_hi_q), .b(b_hi_q), .cin(lo_c_q),
        .s(hi_sum), .cout(hi_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                s_q    <= {hi_sum, lo_s_q};
                cout_q <= hi_co;
            end
        end
    end
`else
    logic [WIDTH-1:0] sum;
    logic             co;

    add11_reg_cla #(.N(WIDTH), .GROUP(GROUP)) u_cla (
        .a(bus.a), .b(bus.b), .cin(bus.cin),
        .s(sum), .cout(co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s_q    <= sum;
                cout_q <= co;
            end
        end
    end
`endif
endmodule

// File: tb/tb_add11_reg.sv
// Bench for add11_reg: directed vectors with hand-computed sums, plus an arithmetic
// delay-line model checked every cycle. Works with or without ADDER_PIPE2_EN.
module tb_add11_reg;
    localparam int W = 11;
`ifdef ADDER_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add11_reg_if #(.WIDTH(W)) bus ();

    add11_reg #(.WIDTH(W), .GROUP(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // hand-computed {cout,s} for each valid beat, in issue order
    logic [W:0] exp_q[$];

    // model: each accepted beat's full sum emerges LAT edges later; values hold otherwise
    logic [W:0] dl_q[$];
    bit         dv_q[$];
    logic [W:0] m_res = '0;
    logic       m_vld = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q.delete();
            dv_q.delete();
            m_res <= '0;
            m_vld <= 1'b0;
        end else begin
            dl_q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin});
            dv_q.push_back(bus.in_valid);
            if (dv_q.size() >= LAT) begin
                if (dv_q[0]) m_res <= dl_q[0];
                m_vld <= dv_q[0];
                void'(dl_q.pop_front());
                void'(dv_q.pop_front());
            end else begin
                m_vld <= 1'b0;
            end
        end
    end

    // compare every cycle, away from the rising edge
    always begin
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== m_vld) begin
            errors++;
            $display("FAIL out_valid: got %0b want %0b at %0t", bus.out_valid, m_vld, $time);
        end
        checks++;
        if ({bus.cout, bus.s} !== m_res) begin
            errors++;
            $display("FAIL model_sum: got cout=%0b s=%0d want cout=%0b s=%0d at %0t",
                     bus.cout, bus.s, m_res[W], m_res[W-1:0], $time);
        end
        if (m_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL directed_sum: got cout=%0b s=%0d want nothing pending",
                         bus.cout, bus.s);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({bus.cout, bus.s} !== e) begin
                    errors++;
                    $display("FAIL directed_sum: got cout=%0b s=%0d want cout=%0b s=%0d at %0t",
                             bus.cout, bus.s, e[W], e[W-1:0], $time);
                end
            end
        end
    end

    // driver tasks: inputs change on the falling edge
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W:0] e);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.a        = W'($urandom_range(0, 2047));
            bus.b        = W'($urandom_range(0, 2047));
            bus.cin      = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.s !== '0 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL %s: got out_valid=%0b s=%0d cout=%0b want 0 0 0",
                     name, bus.out_valid, bus.s, bus.cout);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.in_valid = 1'b0;
        #1;
        check_cleared("reset_initial");
        // reset held with random valid inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a        = W'($urandom_range(0, 2047));
            bus.b        = W'($urandom_range(0, 2047));
            bus.cin      = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        check_cleared("reset_held");
        #2 rst_n = 1'b1;

        drive(11'd0, 11'd1, 1'b0, 12'd1);
        drive(11'd2, 11'd3, 1'b1, 12'd6);
        // back-to-back directed set
        drive(11'd256, 11'd40, 1'b0, 12'd296);
        drive(11'd34,  11'd96, 1'b1, 12'd131);
        drive(11'd36,  11'd1,  1'b0, 12'd37);
        drive(11'd520, 11'd32, 1'b1, 12'd553);
        drive(11'd548, 11'd66, 1'b0, 12'd614);
        drive(11'd546, 11'd80, 1'b1, 12'd627);
        drive(11'd266, 11'd73, 1'b0, 12'd339);
        drive(11'd831, 11'd255, 1'b0, 12'd1086);
        // carry-out and full propagation
        drive(11'd2047, 11'd0,    1'b1, 12'h800);
        drive(11'd2047, 11'd2047, 1'b1, 12'hFFF);
        drive(11'h555,  11'h2AA,  1'b1, 12'h800);
        // two-cycle valid gap, then more sums
        idle(2);
        drive(11'd100,  11'd200,  1'b0, 12'd300);
        drive(11'd1023, 11'd1024, 1'b1, 12'h800);
        drive(11'd1365, 11'd0,    1'b0, 12'd1365);
        idle(1);
        drive(11'd5, 11'd6, 1'b0, 12'd11);
        drive(11'd7, 11'd8, 1'b1, 12'd16);
        // asynchronous reset between edges, mid-stream
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_cleared("reset_midstream");
        idle(2);
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(11'd9, 11'd9, 1'b0, 12'd18);
        idle(LAT + 3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
